// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter fed by a small FIFO. Frames go out back-to-back
// while words are queued, with configurable divisor, width, parity and stop bits.
//
//   state | meaning
//   IDLE  | line high, waiting for a queued word
//   START | start bit, line low
//   DATA  | data bits, LSB first, from the shifter
//   PAR   | parity bit (only when PARITY != 0)
//   STOP  | line high for STOP_BITS bit periods
module uart_tx_param #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 sysclk,
    input  logic                                 reset,
    input  logic [DATA_BITS-1:0]                 TX_DATA,
    input  logic                                 TX_EN,
    output logic                                 TX_STATUS,
    output logic                                 TX_BUSY,
    output logic                                 TX_OVF,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      FIFO_LEVEL,
    output logic                                 UART_TX
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_TC  = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_TC   = BW'(DATA_BITS - 1);
    localparam logic          STOP_TC  = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state_q;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]          level_q, level_d;
    logic [CW-1:0]          baud_q;
    logic [BW-1:0]          bit_q;
    logic                   stop_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic                   tx_q;
    logic                   ovf_q;

    logic                   full, empty, push, pop, baud_tc, frame_end;
    logic [DATA_BITS-1:0]   head;
    logic                   head_par;

    // Full comes from the registered level, so a write while full is dropped
    // even when a pop happens on the same edge.
    assign full      = (level_q == FULL_LVL);
    assign empty     = (level_q == '0);
    assign push      = TX_EN & ~full;
    assign baud_tc   = (baud_q == BAUD_TC);
    assign frame_end = (state_q == STOP) && baud_tc && (stop_q == STOP_TC);
    assign pop       = ~empty & ((state_q == IDLE) | frame_end);
    assign head      = mem_q[rd_ptr_q];
    assign head_par  = (PARITY == 1) ? ~^head : ^head;

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= TX_DATA;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            ovf_q   <= TX_EN & full;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            if (state_q != IDLE) begin
                baud_q <= baud_tc ? '0 : baud_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= START;
                        shift_q <= head;
                        par_q   <= head_par;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_tc) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (baud_tc) begin
                        if (bit_q == BIT_TC) begin
                            if (PARITY != 0) begin
                                state_q <= PAR;
                                tx_q    <= par_q;
                            end else begin
                                state_q <= STOP;
                                stop_q  <= 1'b0;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
                end
                PAR: begin
                    if (baud_tc) begin
                        state_q <= STOP;
                        stop_q  <= 1'b0;
                        tx_q    <= 1'b1;
                    end
                end
                STOP: begin
                    if (baud_tc) begin
                        if (stop_q == STOP_TC) begin
                            // Next queued word starts immediately, no idle bit.
                            if (pop) begin
                                state_q <= START;
                                shift_q <= head;
                                par_q   <= head_par;
                                tx_q    <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            stop_q <= stop_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign UART_TX    = tx_q;
    assign TX_STATUS  = ~full;
    assign TX_BUSY    = (state_q != IDLE) | ~empty;
    assign TX_OVF     = ovf_q;
    assign FIFO_LEVEL = level_q;

endmodule
